// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings and LED drive constants for the LED mode sequencer.
// Optional BREATHE mode is enabled by the LED_BREATHE_EN macro.
package led_ctrl_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 3'd0,
        MODE_STEADY  = 3'd1,
        MODE_BLINK   = 3'd2,
        MODE_ALT     = 3'd3,
        MODE_BREATHE = 3'd4
    } mode_e;

    localparam logic [1:0] LED_ON  = 2'b11;
    localparam logic [1:0] LED_OFF = 2'b00;

endpackage

// File: rtl/pb_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level debounce and
// a single-cycle press pulse on each accepted released->pressed transition.
module pb_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pb_n,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_pb_n;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Registered edge detect: releases (0->1) never produce a pulse.
            r_press   <= r_level_d & ~r_level;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/led_mode_sequencer.sv
// LED pair controller: debounced button steps OFF/STEADY/BLINK/ALT[/BREATHE].
// BREATHE mode and its PWM datapath exist only when LED_BREATHE_EN is defined.
module led_mode_sequencer
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 500000,
    parameter int unsigned BLINK_HALF_CYCLES = 12500000,
    parameter int unsigned PWM_BITS          = 8
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              PB_SW,
    output logic [1:0]        LED,
    output logic [MODE_W-1:0] MODE
);

    localparam int unsigned BLINK_W = (BLINK_HALF_CYCLES > 2) ? $clog2(BLINK_HALF_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_HALF_CYCLES - 1);

    logic               w_pb_level;
    logic               w_pb_press;
    logic               w_press;
    logic               w_mode_change;
    logic [1:0]         w_led_next;
    mode_e              r_mode;
    mode_e              w_mode_next;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_phase;
    logic [1:0]         r_led;

    pb_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pb_debounce (
        .i_clk   (CLK),
        .i_rst_n (RESETn),
        .i_pb_n  (PB_SW),
        .o_level (w_pb_level),
        .o_press (w_pb_press)
    );

    // A press is only honoured while the debounced level still reads pressed.
    assign w_press = w_pb_press & ~w_pb_level;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_mode <= MODE_OFF;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    always_comb begin
        w_mode_next = r_mode;
        case (r_mode)
            MODE_OFF:    if (w_press) w_mode_next = MODE_STEADY;
            MODE_STEADY: if (w_press) w_mode_next = MODE_BLINK;
            MODE_BLINK:  if (w_press) w_mode_next = MODE_ALT;
`ifdef LED_BREATHE_EN
            MODE_ALT:     if (w_press) w_mode_next = MODE_BREATHE;
            MODE_BREATHE: if (w_press) w_mode_next = MODE_OFF;
`else
            MODE_ALT:     if (w_press) w_mode_next = MODE_OFF;
`endif
            default:     w_mode_next = MODE_OFF;
        endcase
    end

    assign w_mode_change = (w_mode_next != r_mode);

    // Mode change wins over a coincident wrap so every mode starts at phase 0.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_mode_change) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == BLINK_MAX) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

`ifdef LED_BREATHE_EN
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_dir_down;
    logic                w_pwm_lit;

    // Duty ramps up then down; the direction flip costs one period at each end.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_pwm_cnt  <= '0;
            r_duty     <= '0;
            r_dir_down <= 1'b0;
        end else if (w_mode_change && (w_mode_next == MODE_BREATHE)) begin
            r_pwm_cnt  <= '0;
            r_duty     <= '0;
            r_dir_down <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            if (&r_pwm_cnt) begin
                if (!r_dir_down) begin
                    if (&r_duty) r_dir_down <= 1'b1;
                    else         r_duty     <= r_duty + PWM_BITS'(1);
                end else begin
                    if (r_duty == '0) r_dir_down <= 1'b0;
                    else              r_duty     <= r_duty - PWM_BITS'(1);
                end
            end
        end
    end

    assign w_pwm_lit = (r_pwm_cnt < r_duty);
`endif

    always_comb begin
        w_led_next = LED_OFF;
        case (r_mode)
            MODE_STEADY:  w_led_next = LED_ON;
            MODE_BLINK:   w_led_next = {r_phase, r_phase};
            MODE_ALT:     w_led_next = {r_phase, ~r_phase};
`ifdef LED_BREATHE_EN
            MODE_BREATHE: w_led_next = {w_pwm_lit, w_pwm_lit};
`endif
            default:      w_led_next = LED_OFF;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_led <= LED_OFF;
        end else begin
            r_led <= w_led_next;
        end
    end

    assign LED  = r_led;
    assign MODE = r_mode;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer with a cycle-accurate expectation
// scoreboard; BREATHE checks follow whether LED_BREATHE_EN is defined.
module tb_led_mode_sequencer;

    logic       CLK;
    logic       RESETn;
    logic       PB_SW;
    logic [1:0] LED;
    logic [2:0] MODE;

    led_mode_sequencer #(
        .DEBOUNCE_CYCLES   (8),
        .BLINK_HALF_CYCLES (4),
        .PWM_BITS          (3)
    ) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .PB_SW  (PB_SW),
        .LED    (LED),
        .MODE   (MODE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string      tag;
        logic [4:0] val;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   edge_n = 0;

    // Reference model state: expected mode after the last edge, edge at which
    // it was entered, and the edge at which a pending press takes effect.
    logic [2:0] m_mode  = 3'd0;
    int         m_entry = 0;
    int         pc      = -1;

    function automatic logic [2:0] next_mode(input logic [2:0] m);
        case (m)
            3'd0: return 3'd1;
            3'd1: return 3'd2;
            3'd2: return 3'd3;
`ifdef LED_BREATHE_EN
            3'd3: return 3'd4;
`endif
            default: return 3'd0;
        endcase
    endfunction

    // LED produced at an edge, given the mode held before it and the number
    // of edges since that mode was entered.
    function automatic logic [1:0] led_for(input logic [2:0] m, input int s);
        logic ph;
        int   p, q16, duty, pwm;
        ph = ((s / 4) % 2) == 1;
        case (m)
            3'd1: return 2'b11;
            3'd2: return {ph, ph};
            3'd3: return {ph, ~ph};
            3'd4: begin
                p    = s / 8;
                pwm  = s % 8;
                q16  = p % 16;
                duty = (q16 < 8) ? q16 : 15 - q16;
                return (pwm < duty) ? 2'b11 : 2'b00;
            end
            default: return 2'b00;
        endcase
    endfunction

    task automatic step();
        @(posedge CLK);
        edge_n++;
        #1;
    endtask

    task automatic check_front();
        exp_t e;
        if (q.size() == 0) begin
            errors++;
            checks++;
            $error("FAIL scoreboard_empty: observed=empty expected=entry");
        end else begin
            e = q.pop_front();
            checks++;
            assert ({MODE, LED} === e.val)
            else begin
                errors++;
                $error("FAIL %s: observed mode=%0d led=%b expected mode=%0d led=%b",
                       e.tag, MODE, LED, e.val[4:2], e.val[1:0]);
            end
        end
    endtask

    task automatic cyc(input string tag);
        int         t;
        logic [1:0] el;
        t  = edge_n + 1;
        el = led_for(m_mode, t - 1 - m_entry);
        if (t == pc) begin
            m_mode  = next_mode(m_mode);
            m_entry = t;
            pc      = -1;
        end
        q.push_back('{tag, {m_mode, el}});
        step();
        check_front();
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    // Drive PB_SW low for 'samples' edges; 8 or more registers a press.
    task automatic press(input int samples, input string tag);
        PB_SW = 1'b0;
        if (samples >= 8) pc = edge_n + 1 + 11;
        run(samples, tag);
        PB_SW = 1'b1;
    endtask

    task automatic reset_cyc(input string tag);
        q.push_back('{tag, 5'b000_00});
        step();
        check_front();
    endtask

    task automatic release_reset();
        RESETn  = 1'b1;
        m_mode  = 3'd0;
        m_entry = edge_n;
        pc      = -1;
    endtask

    initial begin
        RESETn = 1'b0;
        PB_SW  = 1'b1;

        for (int i = 0; i < 10; i++) begin
            PB_SW = i[0];
            reset_cyc("reset_hold");
        end
        PB_SW = 1'b1;
        release_reset();
        run(20, "idle_after_reset");

        for (int i = 0; i < 4; i++) begin
            press(7, "glitch");
            run(2, "glitch_gap");
        end
        run(12, "glitch_settle");

        press(20, "press_latency");
        run(20, "release_no_step");

        press(8, "to_blink");
        run(3, "to_blink");
        run(8, "blink");
        press(8, "blink_press_on_wrap");
        run(3, "to_alt_on_wrap");
        run(20, "alt");

        press(8, "alt_press");
        run(3, "alt_press");
`ifdef LED_BREATHE_EN
        run(150, "breathe");
        press(8, "breathe_press");
        run(3, "breathe_to_off");
`endif
        run(15, "off_after_cycle");

        press(8, "to_steady2");
        run(12, "to_steady2");
        press(8, "to_blink2");
        run(12, "to_blink2");
        press(8, "to_alt2");
        run(10, "alt2");

        #2;
        RESETn = 1'b0;
        #1;
        q.push_back('{"async_reset_immediate", 5'b000_00});
        check_front();
        for (int i = 0; i < 3; i++) reset_cyc("reset_mid_alt");
        release_reset();
        run(5, "idle_after_reset2");
        press(8, "first_press_after_reset");
        run(10, "steady_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
